// File: rtl/npc_mc_core_seq_if.sv
// ---------------------------------------------------------------------------
// npc_mc_core_seq_if
//   Memory-side handshake bundle for the multi-cycle NPC sequencer.
//   Carries two independent req/gnt/rvalid channels:
//     if_*  : instruction fetch (req, addr out; gnt, rvalid, rdata in)
//     lsu_* : data memory     (req, we out;   gnt, rvalid, rdata in)
//   The data-memory address, write data and byte mask come from the
//   external EXU and do not pass through the sequencer.
//   Modports:
//     master : the sequencer (drives requests)
//     slave  : the memory / bus side (drives grants and responses)
// ---------------------------------------------------------------------------
interface npc_mc_core_seq_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [31:0]     if_rdata;

    logic            lsu_req;
    logic            lsu_we;
    logic            lsu_gnt;
    logic            lsu_rvalid;
    logic [XLEN-1:0] lsu_rdata;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output lsu_req, lsu_we,
        input  lsu_gnt, lsu_rvalid, lsu_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  lsu_req, lsu_we,
        output lsu_gnt, lsu_rvalid, lsu_rdata
    );
endinterface

// File: rtl/npc_mc_core_seq.sv
// ---------------------------------------------------------------------------
// npc_mc_core_seq
//   Multi-cycle sequencer for the NPC core. Holds the PC, the instruction
//   register and the control FSM that steps each instruction through
//   FETCH -> IF_WAIT -> EXEC [-> MEM -> MEM_WAIT -> WB] and back to FETCH.
//   The combinational IDU/EXU/GPR live outside; this block only gates their
//   side effects (GPR write enable, data memory request, PC update).
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     bus             fetch and data memory handshakes (master modport)
//     pc, inst        PC register, instruction register (drives IDU)
//     exu_*           decode/execute results from the external EXU
//     gpr_a0          GPR x10, captured as halt code at ebreak
//     gpr_wen         gated GPR write enable
//     wb_sel_load     selects ld_data as GPR write data
//     ld_data         registered load data
//     commit          one-cycle pulse per retired instruction
//     instret         retired-instruction counter (wraps)
//     halted, bus_err sticky stop flags
//     halt_code       gpr_a0 captured at ebreak
// ---------------------------------------------------------------------------
module npc_mc_core_seq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000),
    parameter int              CNT_WIDTH = 64,
    parameter int              TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,

    npc_mc_core_seq_if.master    bus,

    output logic [XLEN-1:0]      pc,
    output logic [31:0]          inst,

    input  logic                 exu_is_load,
    input  logic                 exu_is_store,
    input  logic                 exu_is_ebreak,
    input  logic                 exu_gpr_wen,
    input  logic                 exu_jump_en,
    input  logic [XLEN-1:0]      exu_dnpc,
    input  logic [XLEN-1:0]      gpr_a0,

    output logic                 gpr_wen,
    output logic                 wb_sel_load,
    output logic [XLEN-1:0]      ld_data,

    output logic                 commit,
    output logic [CNT_WIDTH-1:0] instret,
    output logic                 halted,
    output logic                 bus_err,
    output logic [XLEN-1:0]      halt_code
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_IF_WAIT,
        S_EXEC,
        S_MEM,
        S_MEM_WAIT,
        S_WB,
        S_HALT,
        S_ERR
    } state_e;

    // The timeout counter only has to reach TIMEOUT-1.
    localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [31:0]            inst_q, inst_d;
    logic [XLEN-1:0]        ld_data_q, ld_data_d;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]        halt_code_q, halt_code_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    logic                   retire;
    logic                   waiting;
    logic [XLEN-1:0]        next_pc;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= 32'h0000_0013;
            ld_data_q   <= '0;
            instret_q   <= '0;
            halt_code_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            ld_data_q   <= ld_data_d;
            instret_q   <= instret_d;
            halt_code_q <= halt_code_d;
            tmo_q       <= tmo_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        ld_data_d   = ld_data_q;
        instret_d   = instret_q;
        halt_code_d = halt_code_q;
        tmo_d       = tmo_q;

        bus.if_req  = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_we  = 1'b0;
        gpr_wen     = 1'b0;
        wb_sel_load = 1'b0;
        commit      = 1'b0;

        retire      = 1'b0;
        waiting     = 1'b0;
        next_pc     = pc_q + XLEN'(4);

        case (state_q)
            S_FETCH: begin
                bus.if_req = 1'b1;
                waiting    = 1'b1;
                if (bus.if_gnt) begin
                    state_d = S_IF_WAIT;
                end
            end
            S_IF_WAIT: begin
                waiting = 1'b1;
                if (bus.if_rvalid) begin
                    inst_d  = bus.if_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exu_is_ebreak) begin
                    halt_code_d = gpr_a0;
                    commit      = 1'b1;
                    instret_d   = instret_q + CNT_WIDTH'(1);
                    state_d     = S_HALT;
                end else if (exu_is_load || exu_is_store) begin
                    state_d = S_MEM;
                end else begin
                    retire  = 1'b1;
                    gpr_wen = exu_gpr_wen;
                    if (exu_jump_en) begin
                        next_pc = exu_dnpc;
                    end
                end
            end
            S_MEM: begin
                // Address/data/mask come from the EXU and stay stable here
                // because inst and the GPRs are frozen until WB.
                bus.lsu_req = 1'b1;
                bus.lsu_we  = exu_is_store;
                waiting     = 1'b1;
                if (bus.lsu_gnt) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                waiting = 1'b1;
                if (bus.lsu_rvalid) begin
                    if (exu_is_load) begin
                        ld_data_d = bus.lsu_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                retire      = 1'b1;
                gpr_wen     = exu_gpr_wen & exu_is_load;
                wb_sel_load = exu_is_load;
            end
            default: begin
                // S_HALT / S_ERR: absorbing, no side effects.
            end
        endcase

        // Retirement is shared by ALU/branch instructions in EXEC and memory
        // instructions in WB. A misaligned target still retires the
        // instruction but leaves pc pointing at it.
        if (retire) begin
            commit    = 1'b1;
            instret_d = instret_q + CNT_WIDTH'(1);
            if (next_pc[1:0] != 2'b00) begin
                state_d = S_ERR;
            end else begin
                pc_d    = next_pc;
                state_d = S_FETCH;
            end
        end

        // Handshake watchdog: a completed handshake on the last allowed
        // cycle still wins over the timeout.
        if ((TIMEOUT != 0) && waiting && (state_d == state_q)) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERR;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // Any state change restarts the count for the state being entered.
        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    assign bus.if_addr = pc_q;
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign ld_data     = ld_data_q;
    assign instret     = instret_q;
    assign halt_code   = halt_code_q;
    assign halted      = (state_q == S_HALT) || (state_q == S_ERR);
    assign bus_err     = (state_q == S_ERR);

endmodule

// File: tb/tb_npc_mc_core_seq.sv
module tb_npc_mc_core_seq;

    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam int          TMO  = 8;

    localparam logic [3:0] K_ALU = 4'd1;
    localparam logic [3:0] K_BR  = 4'd2;
    localparam logic [3:0] K_LD  = 4'd3;
    localparam logic [3:0] K_ST  = 4'd4;
    localparam logic [3:0] K_EB  = 4'd5;

    localparam int END_RUN  = 0;
    localparam int END_HALT = 1;
    localparam int END_ERR  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    npc_mc_core_seq_if #(.XLEN(XLEN)) bus();

    logic [31:0] pc, inst, exu_dnpc, gpr_a0, ld_data, halt_code;
    logic        exu_is_load, exu_is_store, exu_is_ebreak, exu_gpr_wen, exu_jump_en;
    logic        gpr_wen, wb_sel_load, commit, halted, bus_err;
    logic [63:0] instret;

    npc_mc_core_seq #(
        .XLEN(XLEN), .RESET_PC(RPC), .CNT_WIDTH(64), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pc(pc), .inst(inst),
        .exu_is_load(exu_is_load), .exu_is_store(exu_is_store),
        .exu_is_ebreak(exu_is_ebreak), .exu_gpr_wen(exu_gpr_wen),
        .exu_jump_en(exu_jump_en), .exu_dnpc(exu_dnpc), .gpr_a0(gpr_a0),
        .gpr_wen(gpr_wen), .wb_sel_load(wb_sel_load), .ld_data(ld_data),
        .commit(commit), .instret(instret), .halted(halted),
        .bus_err(bus_err), .halt_code(halt_code)
    );

    // ---------------- program table and stand-in decoder ----------------
    logic [3:0]  tr_kind [256];
    logic        tr_taken[256];
    logic        tr_wen  [256];
    logic [31:0] tr_dnpc [256];
    logic [31:0] tr_ldv  [256];

    logic [7:0] dec_idx;
    logic [3:0] dec_kind;
    always_comb begin
        dec_idx       = inst[7:0];
        dec_kind      = inst[31:28];
        exu_is_load   = (dec_kind == K_LD);
        exu_is_store  = (dec_kind == K_ST);
        exu_is_ebreak = (dec_kind == K_EB);
        exu_gpr_wen   = tr_wen[dec_idx];
        exu_jump_en   = (dec_kind == K_BR) && tr_taken[dec_idx];
        exu_dnpc      = tr_dnpc[dec_idx];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic        sel;
        logic        is_ld;
        logic [31:0] ld;
        logic [63:0] cnt;
    } rec_t;

    rec_t        exp_commit[$];
    logic [31:0] exp_fetch[$];
    logic        exp_we[$];
    logic [31:0] fetch_words[$];
    int          commit_cyc[$];
    int          lsu_runs[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- architectural reference model ----------------
    logic [31:0] m_pc;
    int          m_n;
    int          m_end;

    task automatic add_inst(input logic [3:0] kind, input logic taken, input logic [31:0] dnpc,
                            input logic wen, input logic [31:0] ldv);
        rec_t        r;
        logic [31:0] nxt;
        int          idx;
        idx = m_n;
        tr_kind[idx]  = kind;
        tr_taken[idx] = taken;
        tr_wen[idx]   = wen;
        tr_dnpc[idx]  = dnpc;
        tr_ldv[idx]   = ldv;
        exp_fetch.push_back(m_pc);
        fetch_words.push_back({kind, 20'h0, 8'(idx)});
        if (kind == K_LD || kind == K_ST) exp_we.push_back(kind == K_ST);
        r.pc    = m_pc;
        r.is_ld = (kind == K_LD);
        r.sel   = (kind == K_LD);
        r.ld    = ldv;
        r.wen   = (kind == K_EB || kind == K_ST) ? 1'b0 : wen;
        r.cnt   = 64'(m_n);
        exp_commit.push_back(r);
        nxt = (kind == K_BR && taken) ? dnpc : m_pc + 32'd4;
        if (kind == K_EB) m_end = END_HALT;
        else if (nxt[1:0] != 2'b00) m_end = END_ERR;
        else m_pc = nxt;
        m_n++;
    endtask

    // ---------------- memory responders ----------------
    int f_gfix = -1, f_rfix = -1, l_gfix = -1, l_rfix = -1;
    bit spur = 1'b0;

    function automatic int pick(input int fix);
        return (fix >= 0) ? fix : int'($urandom_range(0, 3));
    endfunction

    initial begin
        int ph, cnt, gd, rd;
        ph = 0; cnt = 0; gd = 0; rd = 0;
        bus.if_gnt = 1'b0; bus.if_rvalid = 1'b0; bus.if_rdata = '0;
        forever begin
            @(negedge clk);
            bus.if_gnt = 1'b0;
            bus.if_rvalid = 1'b0;
            if (!rst_n) begin
                ph = 0; cnt = 0; gd = pick(f_gfix); rd = pick(f_rfix);
            end else if (ph == 0) begin
                if (bus.if_req) begin
                    if (cnt >= gd) begin bus.if_gnt = 1'b1; ph = 1; cnt = 0; end
                    else cnt++;
                end else if (spur && $urandom_range(0, 7) == 0) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = $urandom;
                end
            end else begin
                if (cnt >= rd) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = (fetch_words.size() > 0) ? fetch_words.pop_front() : 32'h0000_0013;
                    ph = 0; cnt = 0; gd = pick(f_gfix); rd = pick(f_rfix);
                end else cnt++;
            end
        end
    end

    initial begin
        int ph, cnt, gd, rd;
        ph = 0; cnt = 0; gd = 0; rd = 0;
        bus.lsu_gnt = 1'b0; bus.lsu_rvalid = 1'b0; bus.lsu_rdata = '0;
        forever begin
            @(negedge clk);
            bus.lsu_gnt = 1'b0;
            bus.lsu_rvalid = 1'b0;
            if (!rst_n) begin
                ph = 0; cnt = 0; gd = pick(l_gfix); rd = pick(l_rfix);
            end else if (ph == 0) begin
                if (bus.lsu_req) begin
                    if (cnt >= gd) begin bus.lsu_gnt = 1'b1; ph = 1; cnt = 0; end
                    else cnt++;
                end else if (spur && $urandom_range(0, 7) == 0) begin
                    bus.lsu_rvalid = 1'b1;
                    bus.lsu_rdata  = $urandom;
                end
            end else begin
                if (cnt >= rd) begin
                    bus.lsu_rvalid = 1'b1;
                    bus.lsu_rdata  = tr_ldv[dec_idx];
                    ph = 0; cnt = 0; gd = pick(l_gfix); rd = pick(l_rfix);
                end else cnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prev_if, prev_lsu;
        int   run;
        rec_t r;
        prev_if = 1'b0; prev_lsu = 1'b0; run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_if = 1'b0; prev_lsu = 1'b0; run = 0;
            end else begin
                if (bus.if_req && !prev_if) begin
                    if (exp_fetch.size() == 0) chk("fetch_unexpected", bus.if_req, 1'b0);
                    else chk("fetch_addr", bus.if_addr, exp_fetch.pop_front());
                end
                if (bus.lsu_req && !prev_lsu) begin
                    if (exp_we.size() == 0) chk("lsu_unexpected", bus.lsu_req, 1'b0);
                    else chk("lsu_we", bus.lsu_we, exp_we.pop_front());
                end
                if (bus.lsu_req) run++;
                else if (run > 0) begin lsu_runs.push_back(run); run = 0; end
                if (commit) begin
                    commit_cyc.push_back(cyc);
                    if (exp_commit.size() == 0) chk("commit_unexpected", commit, 1'b0);
                    else begin
                        r = exp_commit.pop_front();
                        chk("commit_pc", pc, r.pc);
                        chk("commit_gpr_wen", gpr_wen, r.wen);
                        chk("commit_wb_sel", wb_sel_load, r.sel);
                        chk("commit_instret", instret, r.cnt);
                        if (r.is_ld) chk("commit_ld_data", ld_data, r.ld);
                    end
                end
                if (gpr_wen && !commit) chk("gpr_wen_outside_commit", gpr_wen, 1'b0);
                prev_if  = bus.if_req;
                prev_lsu = bus.lsu_req;
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    int c0;

    task automatic start_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_commit.delete(); exp_fetch.delete(); exp_we.delete();
        fetch_words.delete(); commit_cyc.delete(); lsu_runs.delete();
        m_pc = RPC; m_n = 0; m_end = END_RUN;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_stop(input logic exp_err, input logic [31:0] exp_code);
        int t, busy;
        t = 0;
        while (!halted && t < 3000) begin @(negedge clk); t++; end
        #1;
        chk("stopped", halted, 1'b1);
        chk("bus_err", bus_err, exp_err);
        if (!exp_err) chk("halt_code", halt_code, exp_code);
        chk("instret_end", instret, 64'(m_n));
        chk("commits_left", 64'(exp_commit.size()), 64'd0);
        chk("fetches_left", 64'(exp_fetch.size()), 64'd0);
        busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.if_req || bus.lsu_req || commit || gpr_wen) busy++;
        end
        chk("quiet_after_stop", 64'(busy), 64'd0);
    endtask

    // ---------------- tests ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            tr_kind[i] = '0; tr_taken[i] = 1'b0; tr_wen[i] = 1'b0;
            tr_dnpc[i] = '0; tr_ldv[i] = '0;
        end
        gpr_a0 = '0;
        rst_n  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_instret", instret, 64'd0);
        chk("rst_flags", {halted, bus_err, commit, gpr_wen, bus.lsu_req}, 5'd0);

        // three ALU ops at zero wait, commit period of 3 cycles
        f_gfix = 0; f_rfix = 0; l_gfix = 0; l_rfix = 0; spur = 1'b0;
        start_reset();
        add_inst(K_ALU, 1'b0, '0, 1'b1, '0);
        add_inst(K_ALU, 1'b0, '0, 1'b0, '0);
        add_inst(K_ALU, 1'b0, '0, 1'b1, '0);
        add_inst(K_EB,  1'b0, '0, 1'b0, '0);
        gpr_a0 = 32'h0;
        release_reset();
        wait_stop(1'b0, 32'h0);
        if (commit_cyc.size() >= 3) begin
            chk("alu_first_commit", 64'(commit_cyc[0] - c0), 64'd2);
            chk("alu_period_1", 64'(commit_cyc[1] - commit_cyc[0]), 64'd3);
            chk("alu_period_2", 64'(commit_cyc[2] - commit_cyc[1]), 64'd3);
        end else chk("alu_commit_count", 64'(commit_cyc.size()), 64'd4);

        // taken non-writing branch to 8000_0100
        start_reset();
        add_inst(K_ALU, 1'b0, '0, 1'b1, '0);
        add_inst(K_BR,  1'b1, 32'h8000_0100, 1'b0, '0);
        add_inst(K_ALU, 1'b0, '0, 1'b1, '0);
        add_inst(K_EB,  1'b0, '0, 1'b0, '0);
        gpr_a0 = 32'h0000_1234;
        release_reset();
        wait_stop(1'b0, 32'h0000_1234);

        // load with grant delayed 4 cycles, then a store that wants a GPR write
        l_gfix = 4;
        start_reset();
        add_inst(K_LD, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        add_inst(K_ST, 1'b0, '0, 1'b1, 32'h1111_2222);
        add_inst(K_EB, 1'b0, '0, 1'b0, '0);
        gpr_a0 = 32'h0000_0007;
        release_reset();
        wait_stop(1'b0, 32'h0000_0007);
        if (commit_cyc.size() > 0) chk("load_commit_latency", 64'(commit_cyc[0] - c0), 64'd9);
        if (lsu_runs.size() > 0) chk("load_req_held", 64'(lsu_runs[0]), 64'd5);
        chk("ld_data_final", ld_data, 32'hDEAD_BEEF);

        // randomized programs with random handshake delays and stray rvalids
        f_gfix = -1; f_rfix = -1; l_gfix = -1; l_rfix = -1; spur = 1'b1;
        for (int run = 0; run < 6; run++) begin
            logic [31:0] code;
            start_reset();
            for (int k = 0; k < 30; k++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                if (sel < 4)      add_inst(K_ALU, 1'b0, '0, 1'($urandom), '0);
                else if (sel < 6) add_inst(K_BR, 1'($urandom),
                                           RPC + {20'h0, 10'($urandom), 2'b00}, 1'($urandom), '0);
                else if (sel < 8) add_inst(K_LD, 1'b0, '0, 1'($urandom), $urandom);
                else              add_inst(K_ST, 1'b0, '0, 1'($urandom), '0);
            end
            add_inst(K_EB, 1'b0, '0, 1'b0, '0);
            code = $urandom;
            gpr_a0 = code;
            release_reset();
            wait_stop(1'b0, code);
        end
        spur = 1'b0;

        // misaligned jump target: commit pulses, pc stays on the branch
        f_gfix = 0; f_rfix = 0; l_gfix = 0; l_rfix = 0;
        start_reset();
        add_inst(K_ALU, 1'b0, '0, 1'b0, '0);
        add_inst(K_BR,  1'b1, 32'h8000_0102, 1'b0, '0);
        release_reset();
        wait_stop(1'b1, 32'h0);
        chk("misaligned_pc_kept", pc, 32'h8000_0004);

        // fetch never granted: error exactly after TMO cycles in FETCH
        f_gfix = 100000;
        start_reset();
        exp_fetch.push_back(RPC);
        release_reset();
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("tmo_not_yet", bus_err, 1'b0);
        @(posedge clk);
        #1;
        chk("tmo_bus_err", bus_err, 1'b1);
        chk("tmo_halted", halted, 1'b1);
        chk("tmo_req_dropped", bus.if_req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
